// File: rtl/view_datapath.sv
// Board-view datapath: steps through the 8x8 cells and the 28x28 pixels of each
// cell, looks up the cell's piece and emits one VGA plot (x, y, colour) per pixel.
module view_datapath #(
    parameter int unsigned BOX    = 28,
    parameter int unsigned ORIGIN = 8,
    parameter logic [2:0]  LIGHT  = 3'b110,
    parameter logic [2:0]  DARK   = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_xy,
    input  logic       enable_count,
    input  logic       ld_colour,
    input  logic       update_viewXY,
    input  logic       clear_viewXY,
    input  logic       select,
    input  logic       now_player_white,
    input  logic [2:0] cur_x,
    input  logic [2:0] cur_y,
    input  logic [1:0] board_data,
    output logic [5:0] board_addr,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       clear_count,
    output logic       complete
);

    localparam logic [4:0]  LAST_PIX = 5'(BOX - 1);
    localparam logic [10:0] CENTRE2  = 11'(BOX - 1);
    localparam logic [10:0] DISC_R2  = 11'd484;

    logic [2:0] view_x_q, view_x_d, view_y_q, view_y_d;
    logic [4:0] px_q, px_d, py_q, py_d;
    logic [4:0] hold_px_q, hold_px_d, hold_py_q, hold_py_d;
    logic [8:0] base_x_q, base_x_d;
    logic [7:0] base_y_q, base_y_d;
    logic [1:0] piece_q, piece_d;
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       clear_count_q, clear_count_d;

    // Distance from the cell centre in half-pixels: |2p - 27|.
    function automatic logic [10:0] centre_dist(input logic [4:0] p);
        logic [10:0] two_p;
        two_p = {5'd0, p, 1'b0};
        return (two_p >= CENTRE2) ? (two_p - CENTRE2) : (CENTRE2 - two_p);
    endfunction

    function automatic logic on_frame(input logic [4:0] p);
        return (p == 5'd0) || (p == 5'd1) || (p == LAST_PIX - 5'd1) || (p == LAST_PIX);
    endfunction

    function automatic logic [2:0] pixel_colour(
        input logic [2:0] vx,
        input logic [2:0] vy,
        input logic [4:0] hx,
        input logic [4:0] hy,
        input logic [1:0] pc,
        input logic       cursor_cell,
        input logic       sel,
        input logic       white_to_move
    );
        logic [10:0] dx;
        logic [10:0] dy;
        logic [10:0] dist2;
        dx    = centre_dist(hx);
        dy    = centre_dist(hy);
        dist2 = dx * dx + dy * dy;
        if (cursor_cell && sel && (on_frame(hx) || on_frame(hy)))
            return white_to_move ? 3'b001 : 3'b100;
        else if ((pc == 2'b01 || pc == 2'b10) && dist2 <= DISC_R2)
            return (pc == 2'b01) ? 3'b000 : 3'b111;
        else
            return (vx[0] ^ vy[0]) ? DARK : LIGHT;
    endfunction

    always_comb begin
        view_x_d      = view_x_q;
        view_y_d      = view_y_q;
        px_d          = px_q;
        py_d          = py_q;
        hold_px_d     = hold_px_q;
        hold_py_d     = hold_py_q;
        base_x_d      = base_x_q;
        base_y_d      = base_y_q;
        piece_d       = piece_q;
        x_d           = x_q;
        y_d           = y_q;
        colour_d      = colour_q;
        plot_d        = 1'b0;
        clear_count_d = clear_count_q;

        if (clear_viewXY) begin
            view_x_d      = 3'd0;
            view_y_d      = 3'd0;
            px_d          = 5'd0;
            py_d          = 5'd0;
            clear_count_d = 1'b0;
        end else begin
            if (update_viewXY) begin
                view_x_d = view_x_q + 3'd1;
                if (view_x_q == 3'd7)
                    view_y_d = view_y_q + 3'd1;
            end

            if (ld_xy) begin
                base_x_d      = 9'(ORIGIN) + 9'(view_x_q) * 9'(BOX);
                base_y_d      = 8'(ORIGIN) + 8'(view_y_q) * 8'(BOX);
                px_d          = 5'd0;
                py_d          = 5'd0;
                clear_count_d = 1'b0;
                piece_d       = board_data;
            end else if (enable_count && !clear_count_q) begin
                x_d       = base_x_q + {4'd0, px_q};
                y_d       = base_y_q + {3'd0, py_q};
                hold_px_d = px_q;
                hold_py_d = py_q;
                // The counter parks on the last pixel so x/y stay put until the next ld_xy.
                if (px_q == LAST_PIX) begin
                    if (py_q == LAST_PIX) begin
                        clear_count_d = 1'b1;
                    end else begin
                        px_d = 5'd0;
                        py_d = py_q + 5'd1;
                    end
                end else begin
                    px_d = px_q + 5'd1;
                end
            end

            if (ld_colour) begin
                colour_d = pixel_colour(view_x_q, view_y_q, hold_px_q, hold_py_q, piece_q,
                                        (view_x_q == cur_x) && (view_y_q == cur_y),
                                        select, now_player_white);
                plot_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            view_x_q      <= 3'd0;
            view_y_q      <= 3'd0;
            px_q          <= 5'd0;
            py_q          <= 5'd0;
            hold_px_q     <= 5'd0;
            hold_py_q     <= 5'd0;
            base_x_q      <= 9'd0;
            base_y_q      <= 8'd0;
            piece_q       <= 2'b00;
            x_q           <= 9'd0;
            y_q           <= 8'd0;
            colour_q      <= 3'd0;
            plot_q        <= 1'b0;
            clear_count_q <= 1'b0;
        end else begin
            view_x_q      <= view_x_d;
            view_y_q      <= view_y_d;
            px_q          <= px_d;
            py_q          <= py_d;
            hold_px_q     <= hold_px_d;
            hold_py_q     <= hold_py_d;
            base_x_q      <= base_x_d;
            base_y_q      <= base_y_d;
            piece_q       <= piece_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            plot_q        <= plot_d;
            clear_count_q <= clear_count_d;
        end
    end

    assign board_addr  = {view_y_q, view_x_q};
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign plot        = plot_q;
    assign clear_count = clear_count_q;
    assign complete    = update_viewXY && (view_x_q == 3'd7) && (view_y_q == 3'd7);

endmodule

// File: tb/tb_view_datapath.sv
// Bench for view_datapath: vector table, hand-written corner sequences and
// randomised whole-cell draws checked against a per-pixel colour model.
module tb_view_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_xy, enable_count, ld_colour, update_viewXY, clear_viewXY;
    logic       select, now_player_white;
    logic [2:0] cur_x, cur_y;
    logic [1:0] board_data = 2'b00;
    logic [5:0] board_addr;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot, clear_count, complete;

    logic [1:0] mem [64];

    int n_cmp = 0;
    int n_err = 0;

    view_datapath dut (
        .clk(clk), .reset(reset), .ld_xy(ld_xy), .enable_count(enable_count),
        .ld_colour(ld_colour), .update_viewXY(update_viewXY), .clear_viewXY(clear_viewXY),
        .select(select), .now_player_white(now_player_white), .cur_x(cur_x), .cur_y(cur_y),
        .board_data(board_data), .board_addr(board_addr), .x(x), .y(y), .colour(colour),
        .plot(plot), .clear_count(clear_count), .complete(complete)
    );

    always #5 clk = ~clk;

    // Board RAM with one cycle of read latency.
    always @(posedge clk) board_data <= mem[board_addr];

    typedef struct {
        int cx, cy, piece, curx, cury, sel, npw, px, py, ex, ey, ec;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_viewXY = 1'b1;
        tick();
        clear_viewXY = 1'b0;
    endtask

    task automatic goto_cell(input int cx, input int cy);
        pulse_clear();
        update_viewXY = 1'b1;
        repeat (cy * 8 + cx) tick();
        update_viewXY = 1'b0;
        tick();
    endtask

    task automatic load();
        ld_xy = 1'b1;
        tick();
        ld_xy = 1'b0;
    endtask

    task automatic pix();
        enable_count = 1'b1;
        tick();
        enable_count = 1'b0;
        ld_colour = 1'b1;
        tick();
        ld_colour = 1'b0;
    endtask

    function automatic int model_colour(input int cx, input int cy, input int piece,
                                        input int curx, input int cury, input int sel,
                                        input int npw, input int px, input int py);
        int dx, dy;
        bit frame;
        frame = (px < 2) || (px > 25) || (py < 2) || (py > 25);
        dx = 2 * px - 27;
        dy = 2 * py - 27;
        if (cx == curx && cy == cury && sel != 0 && frame) return (npw != 0) ? 1 : 4;
        if ((piece == 1 || piece == 2) && dx * dx + dy * dy <= 484) return (piece == 1) ? 0 : 7;
        return ((cx + cy) % 2 == 0) ? 6 : 2;
    endfunction

    initial begin
        reset = 1'b1;
        ld_xy = 0; enable_count = 0; ld_colour = 0; update_viewXY = 0; clear_viewXY = 0;
        select = 0; now_player_white = 0; cur_x = 0; cur_y = 0;
        for (int i = 0; i < 64; i++) mem[i] = 2'b00;

        vt[0]  = '{0, 0, 0, 7, 7, 0, 0,  0,  0,   8,   8, 6};
        vt[1]  = '{3, 2, 2, 7, 7, 0, 0, 13, 13, 105,  77, 7};
        vt[2]  = '{3, 2, 2, 7, 7, 0, 0,  0,  0,  92,  64, 2};
        vt[3]  = '{3, 2, 2, 3, 2, 1, 1,  1, 13,  93,  77, 1};
        vt[4]  = '{3, 2, 2, 3, 2, 0, 1,  1, 13,  93,  77, 2};
        vt[5]  = '{7, 7, 1, 0, 0, 0, 0, 13, 14, 217, 218, 0};
        vt[6]  = '{7, 7, 1, 0, 0, 0, 0, 27, 27, 231, 231, 6};
        vt[7]  = '{1, 0, 3, 7, 7, 0, 0, 13, 13,  49,  21, 2};
        vt[8]  = '{0, 0, 0, 0, 0, 1, 0, 26,  5,  34,  13, 4};
        vt[9]  = '{2, 5, 2, 7, 7, 0, 0,  3, 13,  67, 161, 7};
        vt[10] = '{2, 5, 2, 7, 7, 0, 0,  2, 13,  66, 161, 2};
        vt[11] = '{2, 5, 2, 2, 5, 1, 0, 13,  0,  77, 148, 4};

        // Reset state
        tick();
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_clear_count", int'(clear_count), 0);
        chk("rst_addr", int'(board_addr), 0);
        reset = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            mem[vt[i].cy * 8 + vt[i].cx] = 2'(vt[i].piece);
            cur_x = 3'(vt[i].curx);
            cur_y = 3'(vt[i].cury);
            select = vt[i].sel[0];
            now_player_white = vt[i].npw[0];
            goto_cell(vt[i].cx, vt[i].cy);
            load();
            repeat (vt[i].py * 28 + vt[i].px + 1) pix();
            chk($sformatf("vec%0d_plot", i), int'(plot), 1);
            chk($sformatf("vec%0d_x", i), int'(x), vt[i].ex);
            chk($sformatf("vec%0d_y", i), int'(y), vt[i].ey);
            chk($sformatf("vec%0d_colour", i), int'(colour), vt[i].ec);
        end
        select = 0;
        for (int i = 0; i < 64; i++) mem[i] = 2'b00;

        // Full cell (0,0): clear_count after the 784th pixel, 785th ignored
        goto_cell(0, 0);
        load();
        repeat (783) pix();
        chk("cc_before_last", int'(clear_count), 0);
        enable_count = 1'b1;
        tick();
        enable_count = 1'b0;
        chk("cc_after_last", int'(clear_count), 1);
        chk("last_x", int'(x), 35);
        chk("last_y", int'(y), 35);
        ld_colour = 1'b1;
        tick();
        ld_colour = 1'b0;
        chk("last_plot", int'(plot), 1);
        tick();
        chk("plot_one_cycle", int'(plot), 0);
        enable_count = 1'b1;
        tick();
        enable_count = 1'b0;
        chk("extra_x", int'(x), 35);
        chk("extra_y", int'(y), 35);
        chk("extra_cc", int'(clear_count), 1);

        // Cell walk to (7,7), complete and wrap
        pulse_clear();
        update_viewXY = 1'b1;
        #1;
        chk("complete_at_00", int'(complete), 0);
        update_viewXY = 1'b0;
        goto_cell(7, 7);
        load();
        chk("addr_77", int'(board_addr), 63);
        pix();
        chk("base_x_77", int'(x), 204);
        chk("base_y_77", int'(y), 204);
        update_viewXY = 1'b1;
        #1;
        chk("complete_at_77", int'(complete), 1);
        tick();
        update_viewXY = 1'b0;
        chk("wrap_addr", int'(board_addr), 0);
        chk("complete_after", int'(complete), 0);

        // ld_xy and enable_count together: ld_xy wins
        goto_cell(1, 0);
        load();
        repeat (5) pix();
        chk("pre_both_x", int'(x), 40);
        ld_xy = 1'b1;
        enable_count = 1'b1;
        tick();
        ld_xy = 1'b0;
        enable_count = 1'b0;
        chk("both_x_held", int'(x), 40);
        pix();
        chk("both_restart_x", int'(x), 36);
        chk("both_restart_y", int'(y), 8);

        // Reset in the middle of a cell
        goto_cell(1, 1);
        load();
        repeat (100) pix();
        chk("pre_rst_plot", int'(plot), 1);
        ld_colour = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_plot", int'(plot), 0);
        chk("mid_rst_x", int'(x), 0);
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_addr", int'(board_addr), 0);
        tick();
        chk("mid_rst_plot_held", int'(plot), 0);
        ld_colour = 1'b0;
        reset = 1'b0;
        tick();

        // clear_viewXY while drawing
        goto_cell(2, 3);
        load();
        repeat (784) pix();
        chk("pre_clear_cc", int'(clear_count), 1);
        chk("pre_clear_addr", int'(board_addr), 26);
        pulse_clear();
        chk("clear_cc", int'(clear_count), 0);
        chk("clear_addr", int'(board_addr), 0);

        // Random whole cells against the model
        for (int n = 0; n < 8; n++) begin
            int cx, cy, pc, curx, cury, sel, npw;
            cx = $urandom_range(0, 7);
            cy = $urandom_range(0, 7);
            pc = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                curx = cx; cury = cy;
            end else begin
                curx = $urandom_range(0, 7); cury = $urandom_range(0, 7);
            end
            sel = $urandom_range(0, 1);
            npw = $urandom_range(0, 1);
            for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
            mem[cy * 8 + cx] = 2'(pc);
            cur_x = 3'(curx);
            cur_y = 3'(cury);
            select = sel[0];
            now_player_white = npw[0];
            goto_cell(cx, cy);
            load();
            for (int py = 0; py < 28; py++) begin
                for (int px = 0; px < 28; px++) begin
                    pix();
                    chk($sformatf("rnd%0d_x(%0d,%0d)", n, px, py), int'(x), 8 + cx * 28 + px);
                    chk($sformatf("rnd%0d_y(%0d,%0d)", n, px, py), int'(y), 8 + cy * 28 + py);
                    chk($sformatf("rnd%0d_col(%0d,%0d)", n, px, py), int'(colour),
                        model_colour(cx, cy, pc, curx, cury, sel, npw, px, py));
                end
            end
            chk($sformatf("rnd%0d_cc", n), int'(clear_count), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
